// File: rtl/multicycle_maindec.sv
// ============================================================================
// Module   : multicycle_maindec
// Brief    : Multicycle MIPS main controller FSM with memory-ready handshake
//            and a stalled-access timeout. Define MULTICYCLE_MAINDEC_BNE_EN
//            to decode BNE (op 000101) into the BRANCH state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_maindec #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       memreq,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       branchne,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic       buserr,
  output logic [3:0] state
);

  localparam logic [3:0] c_FETCH   = 4'd0;
  localparam logic [3:0] c_DECODE  = 4'd1;
  localparam logic [3:0] c_MEMADR  = 4'd2;
  localparam logic [3:0] c_MEMRD   = 4'd3;
  localparam logic [3:0] c_MEMWB   = 4'd4;
  localparam logic [3:0] c_MEMWR   = 4'd5;
  localparam logic [3:0] c_EXECUTE = 4'd6;
  localparam logic [3:0] c_ALUWB   = 4'd7;
  localparam logic [3:0] c_BRANCH  = 4'd8;
  localparam logic [3:0] c_ADDIEX  = 4'd9;
  localparam logic [3:0] c_ADDIWB  = 4'd10;
  localparam logic [3:0] c_JUMP    = 4'd11;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_J     = 6'b000010;
`ifdef MULTICYCLE_MAINDEC_BNE_EN
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
`endif

  // MEM_TIMEOUT = 0 disables the abort entirely; the counter then just wraps.
  localparam logic             c_TMO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_illegal;
  logic             r_buserr;
  logic             w_memstate;
  logic             w_timeout;
  logic             w_illegal_op;

  assign w_memstate = (r_state == c_FETCH) || (r_state == c_MEMRD) || (r_state == c_MEMWR);
  assign w_timeout  = c_TMO_EN && w_memstate && !memready && (r_cnt == c_TMO_LAST);

  // State register and the registered one-cycle status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_FETCH;
      r_illegal <= 1'b0;
      r_buserr  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= w_illegal_op;
      r_buserr  <= w_timeout;
    end
  end

  // Counter is zero outside memory states, so every memory-state entry starts at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_memstate && !memready && !w_timeout) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // Next-state logic
  always_comb begin
    w_next       = c_FETCH;
    w_illegal_op = 1'b0;
    case (r_state)
      c_FETCH:   w_next = memready ? c_DECODE : c_FETCH;
      c_DECODE: begin
        case (op)
          c_OP_RTYPE:        w_next = c_EXECUTE;
          c_OP_LW, c_OP_SW:  w_next = c_MEMADR;
          c_OP_BEQ:          w_next = c_BRANCH;
          c_OP_ADDI:         w_next = c_ADDIEX;
          c_OP_J:            w_next = c_JUMP;
`ifdef MULTICYCLE_MAINDEC_BNE_EN
          c_OP_BNE:          w_next = c_BRANCH;
`endif
          default: begin
            w_next       = c_FETCH;
            w_illegal_op = 1'b1;
          end
        endcase
      end
      c_MEMADR:  w_next = (op == c_OP_SW) ? c_MEMWR : c_MEMRD;
      c_MEMRD: begin
        if (memready)       w_next = c_MEMWB;
        else if (w_timeout) w_next = c_FETCH;
        else                w_next = c_MEMRD;
      end
      c_MEMWB:   w_next = c_FETCH;
      c_MEMWR:   w_next = (memready || w_timeout) ? c_FETCH : c_MEMWR;
      c_EXECUTE: w_next = c_ALUWB;
      c_ALUWB:   w_next = c_FETCH;
      c_BRANCH:  w_next = c_FETCH;
      c_ADDIEX:  w_next = c_ADDIWB;
      c_ADDIWB:  w_next = c_FETCH;
      c_JUMP:    w_next = c_FETCH;
      default:   w_next = c_FETCH;
    endcase
  end

  // Output logic; reset overrides everything so the datapath sees a quiet bus
  always_comb begin
    memreq   = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    branchne = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    case (r_state)
      c_FETCH: begin
        memreq  = 1'b1;
        alusrcb = 2'b01;
        irwrite = memready;
        pcwrite = memready;
      end
      c_DECODE:  alusrcb = 2'b11;
      c_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      c_MEMRD: begin
        memreq = 1'b1;
        iord   = 1'b1;
      end
      c_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      c_MEMWR: begin
        memreq   = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      c_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      c_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      c_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = (op == c_OP_BEQ);
`ifdef MULTICYCLE_MAINDEC_BNE_EN
        branchne = (op == c_OP_BNE);
`else
        branchne = 1'b0;
`endif
      end
      c_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      c_ADDIWB:  regwrite = 1'b1;
      c_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    illegal = r_illegal;
    buserr  = r_buserr;
    state   = r_state;
    if (reset) begin
      memreq   = 1'b0;
      memwrite = 1'b0;
      iord     = 1'b0;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      branchne = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      aluop    = 2'b00;
      illegal  = 1'b0;
      buserr   = 1'b0;
      state    = 4'd0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_maindec.sv
// ============================================================================
// Module   : tb_multicycle_maindec
// Brief    : Table-driven cycle-by-cycle check of multicycle_maindec with
//            MEM_TIMEOUT = 4, plus cycles-per-instruction sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_maindec;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic       memready = 1'b0;
  logic       memreq, memwrite, iord, irwrite, pcwrite, branch, branchne;
  logic       regdst, memtoreg, regwrite, alusrca, illegal, buserr;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;

  multicycle_maindec #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .op(op), .memready(memready),
    .memreq(memreq), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcwrite(pcwrite), .branch(branch), .branchne(branchne), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal),
    .buserr(buserr), .state(state)
  );

  always #5 clk = ~clk;

  // Output word bit positions
  localparam logic [22:0] MREQ  = 23'h400000, MWR  = 23'h200000, IORD = 23'h100000;
  localparam logic [22:0] IRW   = 23'h080000, PCW  = 23'h040000, BEQ  = 23'h020000;
  localparam logic [22:0] BNE   = 23'h010000, RDST = 23'h008000, M2R  = 23'h004000;
  localparam logic [22:0] RW    = 23'h002000, ASA  = 23'h001000;
  localparam logic [22:0] SB01  = 23'h000400, SB10 = 23'h000800, SB11 = 23'h000C00;
  localparam logic [22:0] PC01  = 23'h000100, PC10 = 23'h000200;
  localparam logic [22:0] AOSUB = 23'h000040, AOFN = 23'h000080;
  localparam logic [22:0] ILL   = 23'h000020, BERR = 23'h000010;

  localparam logic [22:0] E_F    = MREQ | SB01 | 23'd0;
  localparam logic [22:0] E_FR   = E_F | IRW | PCW;
  localparam logic [22:0] E_DEC  = SB11 | 23'd1;
  localparam logic [22:0] E_MA   = ASA | SB10 | 23'd2;
  localparam logic [22:0] E_MR   = MREQ | IORD | 23'd3;
  localparam logic [22:0] E_MWB  = M2R | RW | 23'd4;
  localparam logic [22:0] E_MW   = MREQ | MWR | IORD | 23'd5;
  localparam logic [22:0] E_EX   = ASA | AOFN | 23'd6;
  localparam logic [22:0] E_AWB  = RDST | RW | 23'd7;
  localparam logic [22:0] E_BR   = ASA | AOSUB | PC01 | 23'd8;
  localparam logic [22:0] E_AIX  = ASA | SB10 | 23'd9;
  localparam logic [22:0] E_AIWB = RW | 23'd10;
  localparam logic [22:0] E_J    = PC10 | PCW | 23'd11;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [22:0] exp;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  wire [22:0] got = {memreq, memwrite, iord, irwrite, pcwrite, branch, branchne,
                     regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, aluop,
                     illegal, buserr, state};

  task automatic add(input logic r, input logic [5:0] o, input logic m, input logic [22:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.mr = m; v.exp = e;
    vq.push_back(v);
  endtask

  // Run one instruction from FETCH with zero-wait memory and count its cycles
  task automatic measure(input logic [5:0] o, input int want);
    int cyc;
    op = o;
    memready = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (state != 4'd0 && cyc < 20);
    n_vec++;
    if (cyc != want) begin
      n_bad++;
      $display("FAIL cpi op=%b: got %0d cycles want %0d", o, cyc, want);
    end
  endtask

  initial begin
    // R-type, zero-wait
    add(1, 6'h00, 1, 23'd0);
    add(0, 6'h00, 1, E_FR);
    add(0, 6'h00, 0, E_DEC);
    add(0, 6'h00, 0, E_EX);
    add(0, 6'h00, 0, E_AWB);
    // LW with 2 waits in FETCH and 2 in MEMRD: 9 cycles
    add(0, 6'h23, 0, E_F);
    add(0, 6'h23, 0, E_F);
    add(0, 6'h23, 1, E_FR);
    add(0, 6'h23, 0, E_DEC);
    add(0, 6'h23, 0, E_MA);
    add(0, 6'h23, 0, E_MR);
    add(0, 6'h23, 0, E_MR);
    add(0, 6'h23, 1, E_MR);
    add(0, 6'h23, 0, E_MWB);
    // SW that times out in MEMWR after 4 cycles
    add(0, 6'h2B, 1, E_FR);
    add(0, 6'h2B, 0, E_DEC);
    add(0, 6'h2B, 0, E_MA);
    for (int i = 0; i < 4; i++) add(0, 6'h2B, 0, E_MW);
    add(0, 6'h2B, 1, E_FR | BERR);
    // Unsupported opcode
    add(0, 6'h3F, 0, E_DEC);
    add(0, 6'h3F, 1, E_FR | ILL);
    // BNE opcode
    add(0, 6'h05, 0, E_DEC);
`ifdef MULTICYCLE_MAINDEC_BNE_EN
    add(0, 6'h05, 0, E_BR | BNE);
    add(0, 6'h05, 1, E_FR);
`else
    add(0, 6'h05, 1, E_FR | ILL);
`endif
    // BEQ
    add(0, 6'h04, 0, E_DEC);
    add(0, 6'h04, 0, E_BR | BEQ);
    add(0, 6'h08, 1, E_FR);
    // ADDI
    add(0, 6'h08, 0, E_DEC);
    add(0, 6'h08, 0, E_AIX);
    add(0, 6'h08, 0, E_AIWB);
    add(0, 6'h02, 1, E_FR);
    // J, then a FETCH that times out and re-enters FETCH
    add(0, 6'h02, 0, E_DEC);
    add(0, 6'h02, 0, E_J);
    for (int i = 0; i < 4; i++) add(0, 6'h23, 0, E_F);
    add(0, 6'h23, 0, E_F | BERR);
    add(0, 6'h23, 1, E_FR);
    // LW with memready arriving in the last allowed cycle: no abort
    add(0, 6'h23, 0, E_DEC);
    add(0, 6'h23, 0, E_MA);
    for (int i = 0; i < 3; i++) add(0, 6'h23, 0, E_MR);
    add(0, 6'h23, 1, E_MR);
    add(0, 6'h23, 0, E_MWB);
    add(0, 6'h23, 1, E_FR);
    // Reset during a MEMRD wait; counter must restart from zero
    add(0, 6'h23, 0, E_DEC);
    add(0, 6'h23, 0, E_MA);
    for (int i = 0; i < 3; i++) add(0, 6'h23, 0, E_MR);
    add(1, 6'h23, 0, 23'd0);
    add(1, 6'h23, 0, 23'd0);
    for (int i = 0; i < 4; i++) add(0, 6'h23, 0, E_F);
    add(0, 6'h23, 1, E_FR | BERR);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset    = vq[i].rst;
      op       = vq[i].op;
      memready = vq[i].mr;
      #1;
      n_vec++;
      if (got !== vq[i].exp) begin
        n_bad++;
        $display("FAIL vec%0d: got %h want %h", i, got, vq[i].exp);
      end
    end

    // Cycles per instruction from a clean reset
    @(negedge clk);
    reset = 1'b1;
    memready = 1'b1;
    #1;
    n_vec++;
    if (got !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_quiet: got %h want %h", got, 23'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    measure(6'h02, 3);
    measure(6'h04, 3);
    measure(6'h00, 4);
    measure(6'h08, 4);
    measure(6'h2B, 4);
    measure(6'h23, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
